// File: rtl/register_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : register_stage_if
// Description : Issue, execute/AU and debug bundle for register_stage.
//               The slave side is the stage; the master side is whatever
//               issues instructions and supplies the AU result.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_stage_if #(
  parameter int WIDTH = 8
);
  logic                    issueValid;
  logic                    issueReady;
  logic [2:0]              issueOpcode;
  logic [1:0]              issueDest;
  logic [1:0]              issueSrcA;
  logic [1:0]              issueSrcB;
  logic                    issueImmSel;
  logic [WIDTH-1:0]        issueImm;
  logic                    hold;
  logic [2:0]              opcode;
  logic signed [WIDTH-1:0] operandA;
  logic signed [WIDTH-1:0] operandB;
  logic signed [WIDTH-1:0] result;
  logic                    zeroFlag;
  logic                    negativeFlag;
  logic [7:0]              retiredCount;
  logic [1:0]              dbgAddr;
  logic [WIDTH-1:0]        dbgData;

  modport master (
    output issueValid, issueOpcode, issueDest, issueSrcA, issueSrcB,
           issueImmSel, issueImm, hold, result, dbgAddr,
    input  issueReady, opcode, operandA, operandB, zeroFlag, negativeFlag,
           retiredCount, dbgData
  );

  modport slave (
    input  issueValid, issueOpcode, issueDest, issueSrcA, issueSrcB,
           issueImmSel, issueImm, hold, result, dbgAddr,
    output issueReady, opcode, operandA, operandB, zeroFlag, negativeFlag,
           retiredCount, dbgData
  );
endinterface
`default_nettype wire

// File: rtl/register_stage.sv
`default_nettype none
// ============================================================================
// Module      : register_stage
// Description : Single-entry execute stage with a small register file.
//               Operands are captured on issue (with forwarding from the
//               retiring instruction), presented to an external AU, and the
//               AU result is written back when the entry retires.
// Revision    : 1.0 - initial release
// ============================================================================
module register_stage #(
  parameter int WIDTH = 8,
  parameter int REGS  = 4
) (
  input  wire logic      clock,
  input  wire logic      reset,
  register_stage_if.slave bus
);

  localparam logic [2:0] C_OP_NOP = 3'b000;

  // Architectural and execute-stage state
  logic [WIDTH-1:0]        regs_q [REGS];
  logic [WIDTH-1:0]        regs_d [REGS];
  logic                    ex_valid_q, ex_valid_d;
  logic [2:0]              opcode_q, opcode_d;
  logic signed [WIDTH-1:0] operand_a_q, operand_a_d;
  logic signed [WIDTH-1:0] operand_b_q, operand_b_d;
  logic [1:0]              dest_q, dest_d;
  logic                    zero_q, zero_d;
  logic                    neg_q, neg_d;
  logic [7:0]              count_q, count_d;

  logic                    accept;
  logic                    retire;
  logic                    retire_write;
  logic                    fwd_a;
  logic                    fwd_b;
  logic [WIDTH-1:0]        read_a;
  logic [WIDTH-1:0]        read_b;

  // Handshake, retirement qualifiers and forwarded operand selection
  always_comb begin
    accept       = bus.issueValid && !bus.hold;
    retire       = ex_valid_q && !bus.hold;
    retire_write = retire && (opcode_q != C_OP_NOP);
    // The retiring value is written on the same edge the new operands are
    // captured, so the register file still holds the stale value here.
    fwd_a        = retire_write && (dest_q == bus.issueSrcA);
    fwd_b        = retire_write && (dest_q == bus.issueSrcB);
    read_a       = fwd_a ? bus.result : regs_q[bus.issueSrcA];
    read_b       = bus.issueImmSel ? bus.issueImm
                 : (fwd_b ? bus.result : regs_q[bus.issueSrcB]);
  end

  // Next-state: writeback/flags/count on retirement, then execute-stage load
  always_comb begin
    regs_d      = regs_q;
    ex_valid_d  = ex_valid_q;
    opcode_d    = opcode_q;
    operand_a_d = operand_a_q;
    operand_b_d = operand_b_q;
    dest_d      = dest_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    count_d     = count_q;

    if (retire) begin
      count_d = count_q + 8'd1;
      if (retire_write) begin
        regs_d[dest_q] = bus.result;
        zero_d         = (bus.result == '0);
        neg_d          = bus.result[WIDTH-1];
      end
    end

    if (!bus.hold) begin
      if (accept) begin
        ex_valid_d  = 1'b1;
        opcode_d    = bus.issueOpcode;
        operand_a_d = read_a;
        operand_b_d = read_b;
        dest_d      = bus.issueDest;
      end else begin
        ex_valid_d  = 1'b0;
        opcode_d    = C_OP_NOP;
      end
    end
  end

  // State registers; reset drops any in-flight instruction immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) begin
        regs_q[i] <= '0;
      end
      ex_valid_q  <= 1'b0;
      opcode_q    <= C_OP_NOP;
      operand_a_q <= '0;
      operand_b_q <= '0;
      dest_q      <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      regs_q      <= regs_d;
      ex_valid_q  <= ex_valid_d;
      opcode_q    <= opcode_d;
      operand_a_q <= operand_a_d;
      operand_b_q <= operand_b_d;
      dest_q      <= dest_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      count_q     <= count_d;
    end
  end

  // Output drive; the debug read taps the register file with no bypass
  always_comb begin
    bus.issueReady   = !bus.hold;
    bus.opcode       = opcode_q;
    bus.operandA     = operand_a_q;
    bus.operandB     = operand_b_q;
    bus.zeroFlag     = zero_q;
    bus.negativeFlag = neg_q;
    bus.retiredCount = count_q;
    bus.dbgData      = regs_q[bus.dbgAddr];
  end

endmodule
`default_nettype wire
